// File: rtl/cis_capture.sv
// CMOS image sensor capture front end: sync edge detection, skip-then-capture FSM, Bayer-aligned crop.
// Optional frame-size status logic is enabled by defining CIS_CAPTURE_STAT_EN.
module cis_capture #(
   parameter int unsigned SKIP_FRAMES = 4,
   parameter int unsigned IMG_W       = 1280,
   parameter int unsigned IMG_H       = 720
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        capture_en,
   input  logic        cis_vs,
   input  logic        cis_href,
   input  logic [7:0]  cis_data,
   input  logic [11:0] crop_x,
   input  logic [11:0] crop_y,
   input  logic [11:0] crop_w,
   input  logic [11:0] crop_h,
   output logic        vs_o,
   output logic        de_o,
   output logic [7:0]  data_o,
   output logic [15:0] frame_cnt_o,
   output logic [11:0] line_width_o,
   output logic [11:0] frame_height_o,
   output logic        size_err_o
);

   if (SKIP_FRAMES < 1 || SKIP_FRAMES > 15 || IMG_W > 4095 || IMG_H > 4095) begin : g_param_chk
      $error("cis_capture: parameter out of range");
   end

   typedef enum logic [1:0] {IDLE, SKIP, ACTIVE} state_t;

   state_t      state_q, state_d;
   logic [3:0]  skip_cnt_q, skip_cnt_d;
   logic        vs1_q, vs1_d, href1_q, href1_d, vs2_q, vs2_d, href2_q, href2_d;
   logic [7:0]  data1_q, data1_d;
   logic [11:0] pix_x_q, pix_x_d, line_y_q, line_y_d;
   logic [11:0] x0_q, x0_d, w_q, w_d, y0_q, y0_d, h_q, h_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic        vs_o_q, vs_o_d, de_o_q, de_o_d;
   logic [7:0]  data_o_q, data_o_d;

   logic        frame_start, line_end, active, in_win;
   logic [11:0] line_y_inc;
   logic [12:0] x_end, y_end;

   assign frame_start = vs1_q & ~vs2_q;
   assign line_end    = ~href1_q & href2_q;
   // Line end is applied before a coincident frame start clears line_y.
   assign line_y_inc  = (line_end && line_y_q != '1) ? line_y_q + 12'd1 : line_y_q;
   assign x_end       = {1'b0, x0_q} + {1'b0, w_q};
   assign y_end       = {1'b0, y0_q} + {1'b0, h_q};
   assign in_win      = (pix_x_q >= x0_q) && ({1'b0, pix_x_q} < x_end) &&
                        (line_y_q >= y0_q) && ({1'b0, line_y_q} < y_end);

   always_comb begin
      state_d     = state_q;
      skip_cnt_d  = skip_cnt_q;
      x0_d        = x0_q;
      w_d         = w_q;
      y0_d        = y0_q;
      h_d         = h_q;
      vs1_d       = cis_vs;
      href1_d     = cis_href;
      data1_d     = cis_data;
      vs2_d       = vs1_q;
      href2_d     = href1_q;
      pix_x_d     = pix_x_q;
      if (line_end) begin
         pix_x_d = '0;
      end else if (href1_q && pix_x_q != '1) begin
         pix_x_d = pix_x_q + 12'd1;
      end
      line_y_d = frame_start ? '0 : line_y_inc;
      if (frame_start) begin
         x0_d = {crop_x[11:1], 1'b0};
         w_d  = {crop_w[11:1], 1'b0};
         y0_d = {crop_y[11:1], 1'b0};
         h_d  = {crop_h[11:1], 1'b0};
      end
      unique case (state_q)
         IDLE: begin
            if (frame_start && capture_en) begin
               state_d    = SKIP;
               skip_cnt_d = '0;
            end
         end
         SKIP: begin
            if (frame_start) begin
               if (skip_cnt_q == 4'(SKIP_FRAMES)) state_d = ACTIVE;
               else skip_cnt_d = skip_cnt_q + 4'd1;
            end
         end
         ACTIVE: begin
            if (frame_start && !capture_en) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Outputs follow the next state so the frame that enters ACTIVE is delivered whole.
      active      = (state_d == ACTIVE);
      frame_cnt_d = (frame_start && active) ? frame_cnt_q + 16'd1 : frame_cnt_q;
      vs_o_d      = active & vs1_q;
      de_o_d      = active & href1_q & in_win;
      data_o_d    = de_o_d ? data1_q : '0;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         skip_cnt_q  <= '0;
         vs1_q       <= 1'b0;
         href1_q     <= 1'b0;
         data1_q     <= '0;
         vs2_q       <= 1'b0;
         href2_q     <= 1'b0;
         pix_x_q     <= '0;
         line_y_q    <= '0;
         x0_q        <= '0;
         w_q         <= '0;
         y0_q        <= '0;
         h_q         <= '0;
         frame_cnt_q <= '0;
         vs_o_q      <= 1'b0;
         de_o_q      <= 1'b0;
         data_o_q    <= '0;
      end else begin
         state_q     <= state_d;
         skip_cnt_q  <= skip_cnt_d;
         vs1_q       <= vs1_d;
         href1_q     <= href1_d;
         data1_q     <= data1_d;
         vs2_q       <= vs2_d;
         href2_q     <= href2_d;
         pix_x_q     <= pix_x_d;
         line_y_q    <= line_y_d;
         x0_q        <= x0_d;
         w_q         <= w_d;
         y0_q        <= y0_d;
         h_q         <= h_d;
         frame_cnt_q <= frame_cnt_d;
         vs_o_q      <= vs_o_d;
         de_o_q      <= de_o_d;
         data_o_q    <= data_o_d;
      end
   end

   assign vs_o        = vs_o_q;
   assign de_o        = de_o_q;
   assign data_o      = data_o_q;
   assign frame_cnt_o = frame_cnt_q;

`ifdef CIS_CAPTURE_STAT_EN
   logic [11:0] line_width_q, line_width_d, frame_height_q, frame_height_d;
   logic        size_err_q, size_err_d;

   always_comb begin
      line_width_d   = line_end ? pix_x_q : line_width_q;
      frame_height_d = frame_start ? line_y_inc : frame_height_q;
      size_err_d     = size_err_q;
      if (state_q == ACTIVE) begin
         if (line_end && pix_x_q != 12'(IMG_W)) size_err_d = 1'b1;
         if (frame_start && line_y_inc != 12'(IMG_H)) size_err_d = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         line_width_q   <= '0;
         frame_height_q <= '0;
         size_err_q     <= 1'b0;
      end else begin
         line_width_q   <= line_width_d;
         frame_height_q <= frame_height_d;
         size_err_q     <= size_err_d;
      end
   end

   assign line_width_o   = line_width_q;
   assign frame_height_o = frame_height_q;
   assign size_err_o     = size_err_q;
`else
   assign line_width_o   = '0;
   assign frame_height_o = '0;
   assign size_err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_cis_capture.sv
// Table-driven frame-level bench for cis_capture: per-frame crop/enable vectors with hand-computed
// pixel counts, a 2-clock expected-output pipeline, plus an async-reset mid-line sequence.
module tb_cis_capture;

   localparam int TB_W = 16;
   localparam int TB_H = 8;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        capture_en = 1'b0;
   logic        cis_vs = 1'b0;
   logic        cis_href = 1'b0;
   logic [7:0]  cis_data = '0;
   logic [11:0] crop_x = '0, crop_y = '0, crop_w = '0, crop_h = '0;
   logic        vs_o, de_o, size_err_o;
   logic [7:0]  data_o;
   logic [15:0] frame_cnt_o;
   logic [11:0] line_width_o, frame_height_o;

   cis_capture #(.SKIP_FRAMES(4), .IMG_W(TB_W), .IMG_H(TB_H)) dut (
      .clock(clock), .reset_n(reset_n), .capture_en(capture_en),
      .cis_vs(cis_vs), .cis_href(cis_href), .cis_data(cis_data),
      .crop_x(crop_x), .crop_y(crop_y), .crop_w(crop_w), .crop_h(crop_h),
      .vs_o(vs_o), .de_o(de_o), .data_o(data_o), .frame_cnt_o(frame_cnt_o),
      .line_width_o(line_width_o), .frame_height_o(frame_height_o), .size_err_o(size_err_o)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic en; logic en_mid; logic scramble; logic active;
      int cx; int cy; int cw; int ch; int fw; int fh; int exp_de; int exp_fcnt;
   } fvec_t;

   int          n_vec = 0, n_err = 0;
   int          tr_err, de_seen;
   logic [9:0]  pipe0 = '0, pipe1 = '0;
   int          prev_lines = 0, m_lw = 0, m_fh = 0;
   logic        prev_active = 1'b0, m_err = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Outputs seen now belong to the pins driven two ticks earlier.
   task automatic tick(input logic v, input logic h, input logic [7:0] d,
                       input logic e_vs, input logic e_de);
      @(negedge clock);
      if ({vs_o, de_o, data_o} !== pipe1) tr_err++;
      if (de_o === 1'b1) de_seen++;
      pipe1 = pipe0;
      pipe0 = {e_vs, e_de, (e_de ? d : 8'h00)};
      cis_vs = v; cis_href = h; cis_data = d;
   endtask

   function automatic fvec_t mk(logic en, logic en_mid, logic scr, logic act, int cx, int cy,
                                int cw, int ch, int fw, int fh, int de, int fc);
      fvec_t f;
      f.en = en; f.en_mid = en_mid; f.scramble = scr; f.active = act;
      f.cx = cx; f.cy = cy; f.cw = cw; f.ch = ch; f.fw = fw; f.fh = fh;
      f.exp_de = de; f.exp_fcnt = fc;
      return f;
   endfunction

   task automatic run_frame(input string tag, input fvec_t f);
      int x0, w, y0, h;
      logic win;
      x0 = f.cx & ~1; w = f.cw & ~1; y0 = f.cy & ~1; h = f.ch & ~1;
      tr_err = 0; de_seen = 0;
      capture_en = f.en;
      crop_x = 12'(f.cx); crop_y = 12'(f.cy); crop_w = 12'(f.cw); crop_h = 12'(f.ch);
`ifdef CIS_CAPTURE_STAT_EN
      if (prev_active && prev_lines != TB_H) m_err = 1'b1;
      m_fh = prev_lines;
`endif
      tick(1'b1, 1'b0, 8'h00, f.active, 1'b0);
      tick(1'b1, 1'b0, 8'h00, f.active, 1'b0);
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      capture_en = f.en_mid;
      if (f.scramble) begin
         crop_x = '0; crop_y = '0; crop_w = 12'hffe; crop_h = 12'hffe;
      end
      for (int y = 0; y < f.fh; y++) begin
         for (int x = 0; x < f.fw; x++) begin
            win = f.active && (x >= x0) && (x < x0 + w) && (y >= y0) && (y < y0 + h);
            tick(1'b0, 1'b1, 8'(x * 7 + y * 29 + 1), 1'b0, win);
         end
         for (int g = 0; g < 3; g++) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
`ifdef CIS_CAPTURE_STAT_EN
         m_lw = f.fw;
         if (f.active && f.fw != TB_W) m_err = 1'b1;
`endif
      end
      prev_lines = f.fh; prev_active = f.active;
      check($sformatf("%s trace", tag), tr_err, 0);
      check($sformatf("%s de_count", tag), de_seen, f.exp_de);
      check($sformatf("%s frame_cnt", tag), int'(frame_cnt_o), f.exp_fcnt);
      check($sformatf("%s line_width", tag), int'(line_width_o), m_lw);
      check($sformatf("%s frame_height", tag), int'(frame_height_o), m_fh);
      check($sformatf("%s size_err", tag), int'(size_err_o), int'(m_err));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      fvec_t tbl_a[12];
      fvec_t tbl_b[8];
      for (int i = 0; i < 5; i++) tbl_a[i] = mk(1, 1, 0, 0, 0, 0, 16, 8, 16, 8, 0, 0);
      tbl_a[5]  = mk(1, 1, 1, 1, 0, 0, 16, 8, 16, 8, 128, 1);
      tbl_a[6]  = mk(1, 1, 0, 1, 3, 1, 7, 5, 16, 8, 24, 2);
      tbl_a[7]  = mk(1, 1, 0, 1, 0, 0, 16, 8, 16, 8, 128, 3);
      tbl_a[8]  = mk(1, 1, 1, 1, 101, 3, 641, 5, 800, 8, 2560, 4);
      tbl_a[9]  = mk(1, 1, 0, 1, 1200, 0, 200, 4, 1280, 3, 240, 5);
      tbl_a[10] = mk(1, 1, 0, 1, 0, 0, 0, 8, 16, 8, 0, 6);
      tbl_a[11] = mk(1, 1, 0, 1, 0, 0, 16, 1, 16, 8, 0, 7);
      for (int i = 0; i < 5; i++) tbl_b[i] = mk(1, 1, 0, 0, 0, 0, 16, 8, 16, 8, 0, 0);
      tbl_b[5]  = mk(1, 0, 0, 1, 0, 0, 16, 8, 16, 8, 128, 1);
      tbl_b[6]  = mk(0, 0, 0, 0, 0, 0, 16, 8, 16, 8, 0, 1);
      tbl_b[7]  = mk(1, 1, 0, 0, 0, 0, 16, 8, 16, 8, 0, 1);

      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      check("reset vs_o", int'(vs_o), 0);
      check("reset de_o", int'(de_o), 0);
      check("reset data_o", int'(data_o), 0);
      check("reset frame_cnt", int'(frame_cnt_o), 0);
      check("reset line_width", int'(line_width_o), 0);
      check("reset frame_height", int'(frame_height_o), 0);
      check("reset size_err", int'(size_err_o), 0);
      reset_n = 1'b1;
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

      for (int i = 0; i < 12; i++) run_frame($sformatf("A%0d", i + 1), tbl_a[i]);

      // Async reset in the middle of a delivered line.
      tr_err = 0;
      capture_en = 1'b1; crop_x = '0; crop_y = '0; crop_w = 12'd16; crop_h = 12'd8;
      tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int x = 0; x < 6; x++) tick(1'b0, 1'b1, 8'(x + 100), 1'b0, 1'b1);
      check("midline trace", tr_err, 0);
      check("midline de_o before reset", int'(de_o), 1);
      check("midline frame_cnt before reset", int'(frame_cnt_o), 8);
      reset_n = 1'b0;
      #1;
      check("async reset de_o", int'(de_o), 0);
      check("async reset data_o", int'(data_o), 0);
      check("async reset frame_cnt", int'(frame_cnt_o), 0);
      check("async reset size_err", int'(size_err_o), 0);
      pipe0 = '0; pipe1 = '0; tr_err = 0;
      cis_vs = 1'b0; cis_href = 1'b0; cis_data = '0;
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      reset_n = 1'b1;
      tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      check("reset hold trace", tr_err, 0);
      prev_lines = 0; prev_active = 1'b0; m_lw = 0; m_fh = 0; m_err = 1'b0;

      for (int i = 0; i < 8; i++) run_frame($sformatf("B%0d", i + 1), tbl_b[i]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
